ripple_carry_adder: RTL and testbench
=====================================

Name: ripple_carry_adder

Overview:
- Registered, parameterizable-width binary adder.
- Built as an explicit chain of full-adder cells; the carry ripples from bit 0 to bit WIDTH-1.
- Used as a small arithmetic datapath element. The add itself is combinational; the result, carry-out, signed-overflow flag and a valid strobe are registered with 1-cycle latency.

Parameters:
- WIDTH, 4, operand and sum width in bits; must be >= 1.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operands on a/b/cin are valid this cycle
- a  input  WIDTH  operand A, unsigned (also read as two's complement for overflow)
- b  input  WIDTH  operand B
- cin  input  1  carry-in to bit 0
- sum  output  WIDTH  registered sum bits
- cout  output  1  registered carry-out of bit WIDTH-1
- overflow  output  1  registered two's-complement overflow
- out_valid  output  1  sum/cout/overflow updated by the previous cycle's in_valid

Behaviour:
- Combinational core, bit i = 0..WIDTH-1 with c[0] = cin:
  - s[i] = a[i] ^ b[i] ^ c[i]
  - c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]))
- Implement as WIDTH instances of a full-adder cell via generate. No carry-lookahead.
- Combinational result is exact: {c[WIDTH], s} = a + b + cin, a (WIDTH+1)-bit value.
- Overflow = c[WIDTH] ^ c[WIDTH-1]. This equals: a and b have the same MSB and s[MSB] differs from it.
- Reset:
  - rst_n low asynchronously forces sum = 0, cout = 0, overflow = 0, out_valid = 0, with no clock needed.
  - Deassertion takes effect at the next rising clk.
- Rising clk with rst_n high and in_valid = 1:
  - sum <= s, cout <= c[WIDTH], overflow <= computed overflow, out_valid <= 1.
- Rising clk with in_valid = 0:
  - sum, cout and overflow hold their previous values; out_valid <= 0.
- Latency is exactly 1 cycle.
- Throughput is one add per cycle. No backpressure; the consumer must take the result in the cycle out_valid is high.
- Wrap-around: sum is taken modulo 2^WIDTH and the excess appears only on cout. Example: all-ones + 1 gives sum 0, cout 1.
- cin = 1 with a = b = all-ones gives sum all-ones, cout 1.
- Reset asserted mid-stream:
  - Outputs clear immediately.
  - Any operand captured in the same cycle is discarded.
  - out_valid stays 0 until the first in_valid after release.
- Inputs sampled while rst_n is low are ignored.
- Outputs are driven only from flops; no combinational path from inputs to outputs.

Test Plan:
- Reset: assert rst_n=0 mid-cycle with prior nonzero outputs -> sum=0000, cout=0, overflow=0, out_valid=0 immediately, without a clock edge.
- a=0001, b=0010, cin=0, in_valid=1 -> next cycle sum=0011, cout=0, overflow=0, out_valid=1.
- a=0101, b=0011, cin=0 -> sum=1000, cout=0, overflow=1 (positive + positive gives a negative result).
- a=1111, b=0001, cin=0 -> sum=0000, cout=1, overflow=0 (wrap-around).
- a=1010, b=0101, cin=1 -> sum=0000, cout=1, overflow=0 (full carry ripple through all bits).
- Back-to-back and hold:
  - Apply the four vectors above on consecutive cycles -> results appear in order, one per cycle, out_valid high throughout.
  - Then drop in_valid -> out_valid=0 and sum/cout/overflow hold the last result.
- Exhaustive check: all 512 combinations of a, b, cin at WIDTH=4 against the golden value {cout,sum} = a+b+cin.

Source files
------------

// File: rtl/ripple_carry_adder.sv
`default_nettype none
// ============================================================================
// Module   : ripple_carry_adder
// Purpose  : Registered WIDTH-bit adder built from a rippled full-adder chain.
// Revision : 1.0 - initial release
// ============================================================================

module ripple_carry_adder_fa (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);
    logic w_prop;

    assign w_prop = a ^ b;
    assign s      = w_prop ^ ci;
    assign co     = (a & b) | (ci & w_prop);
endmodule

module ripple_carry_adder #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             overflow,
    output logic             out_valid
);
    logic [WIDTH:0]   w_carry;
    logic [WIDTH-1:0] w_sum;
    logic             w_overflow;

    logic [WIDTH-1:0] r_sum;
    logic             r_cout;
    logic             r_overflow;
    logic             r_out_valid;

    assign w_carry[0] = cin;

    generate
        for (genvar i = 0; i < WIDTH; i++) begin : g_fa_chain
            ripple_carry_adder_fa u_fa (
                .a  (a[i]),
                .b  (b[i]),
                .ci (w_carry[i]),
                .s  (w_sum[i]),
                .co (w_carry[i+1])
            );
        end
    endgenerate

    // Carry into and out of the sign bit disagree exactly on signed overflow.
    assign w_overflow = w_carry[WIDTH] ^ w_carry[WIDTH-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sum       <= '0;
            r_cout      <= 1'b0;
            r_overflow  <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            r_out_valid <= in_valid;
            if (in_valid) begin
                r_sum      <= w_sum;
                r_cout     <= w_carry[WIDTH];
                r_overflow <= w_overflow;
            end
        end
    end

    assign sum       = r_sum;
    assign cout      = r_cout;
    assign overflow  = r_overflow;
    assign out_valid = r_out_valid;
endmodule

`default_nettype wire

// File: tb/tb_ripple_carry_adder.sv
`default_nettype none
// ============================================================================
// Module   : tb_ripple_carry_adder
// Purpose  : Scoreboard bench for ripple_carry_adder at WIDTH = 4.
// Revision : 1.0 - initial release
// ============================================================================

module tb_ripple_carry_adder;
    localparam int W = 4;

    typedef struct packed {
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic [W-1:0] sum;
    logic         cout;
    logic         overflow;
    logic         out_valid;

    exp_t q[$];
    exp_t last;
    int   passed = 0;
    int   total  = 0;

    always #5 clk = ~clk;

    ripple_carry_adder #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .sum       (sum),
        .cout      (cout),
        .overflow  (overflow),
        .out_valid (out_valid)
    );

    function automatic exp_t model(input logic [W-1:0] av, input logic [W-1:0] bv, input logic cv);
        logic [W:0] full;
        exp_t       e;
        full   = {1'b0, av} + {1'b0, bv} + {{W{1'b0}}, cv};
        e.sum  = full[W-1:0];
        e.cout = full[W];
        e.ovf  = (av[W-1] == bv[W-1]) && (full[W-1] != av[W-1]);
        return e;
    endfunction

    task automatic apply(input logic [W-1:0] av, input logic [W-1:0] bv, input logic cv);
        in_valid = 1'b1;
        a        = av;
        b        = bv;
        cin      = cv;
        q.push_back(model(av, bv, cv));
    endtask

    task automatic test_reset;
        logic [7:0] got;
        rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0;
        #1;
        got = {out_valid, overflow, cout, 1'b0, sum};
        total++;
        if (got !== 8'h00) $display("FAIL reset_initial: got %b required %b", got, 8'h00);
        else passed++;
        // Operands presented while in reset must not be captured.
        in_valid = 1'b1; a = 4'b0101; b = 4'b0011; cin = 1'b1;
        @(posedge clk); #1;
        got = {out_valid, overflow, cout, 1'b0, sum};
        total++;
        if (got !== 8'h00) $display("FAIL reset_ignores_inputs: got %b required %b", got, 8'h00);
        else passed++;
        in_valid = 1'b0;
        rst_n = 1'b1;
        @(posedge clk); #1;
        got = {out_valid, overflow, cout, 1'b0, sum};
        total++;
        if (got !== 8'h00) $display("FAIL reset_release_idle: got %b required %b", got, 8'h00);
        else passed++;
    endtask

    task automatic test_directed;
        logic [W-1:0] va[4] = '{4'b0001, 4'b0101, 4'b1111, 4'b1010};
        logic [W-1:0] vb[4] = '{4'b0010, 4'b0011, 4'b0001, 4'b0101};
        logic         vc[4] = '{1'b0, 1'b0, 1'b0, 1'b1};
        exp_t         e;
        for (int i = 0; i < 4; i++) begin
            apply(va[i], vb[i], vc[i]);
            @(posedge clk); #1;
            in_valid = 1'b0;
            e = q.pop_front();
            total++;
            if ({out_valid, cout, overflow, sum} !== {1'b1, e.cout, e.ovf, e.sum})
                $display("FAIL directed_%0d: got v=%b c=%b o=%b s=%b required v=1 c=%b o=%b s=%b",
                         i, out_valid, cout, overflow, sum, e.cout, e.ovf, e.sum);
            else passed++;
            @(posedge clk); #1;
            total++;
            if (out_valid !== 1'b0) $display("FAIL directed_idle_%0d: got out_valid=%b required 0", i, out_valid);
            else passed++;
        end
    endtask

    task automatic test_back_to_back;
        logic [W-1:0] va[4] = '{4'b0001, 4'b0101, 4'b1111, 4'b1010};
        logic [W-1:0] vb[4] = '{4'b0010, 4'b0011, 4'b0001, 4'b0101};
        logic         vc[4] = '{1'b0, 1'b0, 1'b0, 1'b1};
        exp_t         e;
        for (int i = 0; i < 4; i++) begin
            apply(va[i], vb[i], vc[i]);
            @(posedge clk); #1;
            e = q.pop_front();
            last = e;
            total++;
            if ({out_valid, cout, overflow, sum} !== {1'b1, e.cout, e.ovf, e.sum})
                $display("FAIL b2b_%0d: got v=%b c=%b o=%b s=%b required v=1 c=%b o=%b s=%b",
                         i, out_valid, cout, overflow, sum, e.cout, e.ovf, e.sum);
            else passed++;
        end
        // Drop valid with new operands on the bus: outputs must hold.
        in_valid = 1'b0; a = 4'b0111; b = 4'b0111; cin = 1'b0;
        for (int k = 0; k < 2; k++) begin
            @(posedge clk); #1;
            total++;
            if ({out_valid, cout, overflow, sum} !== {1'b0, last.cout, last.ovf, last.sum})
                $display("FAIL hold_%0d: got v=%b c=%b o=%b s=%b required v=0 c=%b o=%b s=%b",
                         k, out_valid, cout, overflow, sum, last.cout, last.ovf, last.sum);
            else passed++;
        end
    endtask

    task automatic test_reset_midstream;
        exp_t       e;
        logic [7:0] got;
        apply(4'b1111, 4'b1111, 1'b1);
        @(posedge clk); #1;
        e = q.pop_front();
        total++;
        if ({out_valid, cout, overflow, sum} !== {1'b1, e.cout, e.ovf, e.sum})
            $display("FAIL pre_reset: got v=%b c=%b o=%b s=%b required v=1 c=%b o=%b s=%b",
                     out_valid, cout, overflow, sum, e.cout, e.ovf, e.sum);
        else passed++;
        // Present an operand, then reset mid-cycle before it can be captured.
        in_valid = 1'b1; a = 4'b0101; b = 4'b0011; cin = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        got = {out_valid, overflow, cout, 1'b0, sum};
        total++;
        if (got !== 8'h00) $display("FAIL async_reset: got %b required %b", got, 8'h00);
        else passed++;
        @(posedge clk); #1;
        got = {out_valid, overflow, cout, 1'b0, sum};
        total++;
        if (got !== 8'h00) $display("FAIL reset_discard: got %b required %b", got, 8'h00);
        else passed++;
        in_valid = 1'b0;
        rst_n = 1'b1;
        @(posedge clk); #1;
        got = {out_valid, overflow, cout, 1'b0, sum};
        total++;
        if (got !== 8'h00) $display("FAIL post_reset_idle: got %b required %b", got, 8'h00);
        else passed++;
        apply(4'b0110, 4'b0011, 1'b1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        e = q.pop_front();
        total++;
        if ({out_valid, cout, overflow, sum} !== {1'b1, e.cout, e.ovf, e.sum})
            $display("FAIL post_reset_add: got v=%b c=%b o=%b s=%b required v=1 c=%b o=%b s=%b",
                     out_valid, cout, overflow, sum, e.cout, e.ovf, e.sum);
        else passed++;
    endtask

    task automatic test_exhaustive;
        exp_t e;
        for (int ai = 0; ai < 16; ai++) begin
            for (int bi = 0; bi < 16; bi++) begin
                for (int ci = 0; ci < 2; ci++) begin
                    apply(ai[W-1:0], bi[W-1:0], ci[0]);
                    @(posedge clk); #1;
                    e = q.pop_front();
                    total++;
                    if ({out_valid, cout, overflow, sum} !== {1'b1, e.cout, e.ovf, e.sum})
                        $display("FAIL exhaustive a=%0d b=%0d cin=%0d: got v=%b c=%b o=%b s=%b required v=1 c=%b o=%b s=%b",
                                 ai, bi, ci, out_valid, cout, overflow, sum, e.cout, e.ovf, e.sum);
                    else passed++;
                end
            end
        end
        in_valid = 1'b0;
        total++;
        if (q.size() !== 0) $display("FAIL scoreboard_drain: got %0d entries required 0", q.size());
        else passed++;
    endtask

    initial begin
        test_reset();
        test_directed();
        test_back_to_back();
        test_reset_midstream();
        test_exhaustive();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

`default_nettype wire
